// File: rtl/input_conditioner.sv
// input_conditioner: brings raw slide switches and pushbuttons into the clkIn
// domain, debounces each key independently, and produces clean levels plus
// one-cycle press/release/change pulses. All outputs come straight from flops.
module input_conditioner #(
  parameter int SW_WIDTH        = 13,
  parameter int KEY_WIDTH       = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int KEY_ACTIVE_LOW  = 1
) (
  input  logic                 clkIn,
  input  logic                 rstNIn,
  input  logic [SW_WIDTH-1:0]  swIn,
  input  logic [KEY_WIDTH-1:0] keyIn,
  output logic [SW_WIDTH-1:0]  swOut,
  output logic                 swChangedOut,
  output logic [KEY_WIDTH-1:0] keyLevelOut,
  output logic [KEY_WIDTH-1:0] keyPressOut,
  output logic [KEY_WIDTH-1:0] keyReleaseOut
);

  // A single-cycle debounce still needs a one-bit counter to keep widths legal.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Warm-up covers the sync pipeline filling plus the change-detect flop.
  localparam int WU_MAX = SYNC_STAGES + 1;
  localparam int WU_W   = $clog2(WU_MAX + 1);
  localparam logic [WU_W-1:0] WU_DONE = WU_W'(WU_MAX);

  // Idle pin level of a key; sync flops reset here so no phantom press appears.
  localparam logic [KEY_WIDTH-1:0] KEY_REL = (KEY_ACTIVE_LOW != 0) ? '1 : '0;

  logic [SW_WIDTH-1:0]  sw_sync_q  [SYNC_STAGES];
  logic [KEY_WIDTH-1:0] key_sync_q [SYNC_STAGES];

  logic [CNT_W-1:0]     cnt_q [KEY_WIDTH];
  logic [CNT_W-1:0]     cnt_d [KEY_WIDTH];
  logic [KEY_WIDTH-1:0] level_q, level_d;
  logic [KEY_WIDTH-1:0] press_q, press_d;
  logic [KEY_WIDTH-1:0] release_q, release_d;

  logic [WU_W-1:0]      wu_q, wu_d;
  logic                 sw_chg_q, sw_chg_d;

  logic [KEY_WIDTH-1:0] key_s;
  logic                 warm_done;

  // Switch synchroniser chain; the last stage is the published switch level.
  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sw_sync_q[i] <= '0;
    end else begin
      sw_sync_q[0] <= swIn;
      for (int i = 1; i < SYNC_STAGES; i++) sw_sync_q[i] <= sw_sync_q[i-1];
    end
  end

  // Key synchroniser chain, reset to the released pin level.
  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      for (int i = 0; i < SYNC_STAGES; i++) key_sync_q[i] <= KEY_REL;
    end else begin
      key_sync_q[0] <= keyIn;
      for (int i = 1; i < SYNC_STAGES; i++) key_sync_q[i] <= key_sync_q[i-1];
    end
  end

  // Normalise synced keys so 1 always means pressed.
  always_comb begin
    key_s = key_sync_q[SYNC_STAGES-1] ^ KEY_REL;
  end

  // Per-key debounce: a key flips only after CNT_MAX+1 consecutive disagreeing
  // samples; any agreeing sample restarts the count.
  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < KEY_WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (key_s[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        cnt_d[i]     = '0;
        level_d[i]   = key_s[i];
        press_d[i]   = key_s[i];
        release_d[i] = ~key_s[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Debounce counters, levels and edge pulses.
  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      for (int i = 0; i < KEY_WIDTH; i++) cnt_q[i] <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      for (int i = 0; i < KEY_WIDTH; i++) cnt_q[i] <= cnt_d[i];
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Warm-up counter saturates; the change pulse is muted until it does.
  // The change flop samples the last two sync stages so it rises on the same
  // edge that updates swOut.
  always_comb begin
    warm_done = (wu_q == WU_DONE);
    wu_d      = warm_done ? wu_q : wu_q + WU_W'(1);
    sw_chg_d  = warm_done &&
                (sw_sync_q[SYNC_STAGES-2] != sw_sync_q[SYNC_STAGES-1]);
  end

  // Warm-up and switch-change registers.
  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      wu_q     <= '0;
      sw_chg_q <= 1'b0;
    end else begin
      wu_q     <= wu_d;
      sw_chg_q <= sw_chg_d;
    end
  end

  assign swOut         = sw_sync_q[SYNC_STAGES-1];
  assign swChangedOut  = sw_chg_q;
  assign keyLevelOut   = level_q;
  assign keyPressOut   = press_q;
  assign keyReleaseOut = release_q;

endmodule
